// File: rtl/wb_arbiter_if.sv
// Writeback arbiter bus: lane results, load returns and the two register-file write ports.
// WB_STATS_EN adds the collision / load-stall counter outputs.
interface wb_arbiter_if #(
    parameter int DEPTH = 4
);
    localparam int PW = $clog2(DEPTH) + 1;

    logic          A_valid_i;
    logic [4:0]    A_rd_addr_i;
    logic [31:0]   A_rd_data_i;
    logic          B_valid_i;
    logic [4:0]    B_rd_addr_i;
    logic [31:0]   B_rd_data_i;
    logic          ld_valid_i;
    logic          ld_ready_o;
    logic [4:0]    ld_rd_addr_i;
    logic [31:0]   ld_data_i;
    logic [4:0]    A_rd_addr_o;
    logic [31:0]   A_rd_data_o;
    logic          A_rd_write_o;
    logic [4:0]    B_rd_addr_o;
    logic [31:0]   B_rd_data_o;
    logic          B_rd_write_o;
    logic [PW-1:0] ld_pending_o;
`ifdef WB_STATS_EN
    logic [15:0]   collision_count_o;
    logic [15:0]   ld_stall_count_o;

    modport slave (
        input  A_valid_i, A_rd_addr_i, A_rd_data_i,
        input  B_valid_i, B_rd_addr_i, B_rd_data_i,
        input  ld_valid_i, ld_rd_addr_i, ld_data_i,
        output ld_ready_o, ld_pending_o,
        output A_rd_addr_o, A_rd_data_o, A_rd_write_o,
        output B_rd_addr_o, B_rd_data_o, B_rd_write_o,
        output collision_count_o, ld_stall_count_o
    );

    modport master (
        output A_valid_i, A_rd_addr_i, A_rd_data_i,
        output B_valid_i, B_rd_addr_i, B_rd_data_i,
        output ld_valid_i, ld_rd_addr_i, ld_data_i,
        input  ld_ready_o, ld_pending_o,
        input  A_rd_addr_o, A_rd_data_o, A_rd_write_o,
        input  B_rd_addr_o, B_rd_data_o, B_rd_write_o,
        input  collision_count_o, ld_stall_count_o
    );
`else
    modport slave (
        input  A_valid_i, A_rd_addr_i, A_rd_data_i,
        input  B_valid_i, B_rd_addr_i, B_rd_data_i,
        input  ld_valid_i, ld_rd_addr_i, ld_data_i,
        output ld_ready_o, ld_pending_o,
        output A_rd_addr_o, A_rd_data_o, A_rd_write_o,
        output B_rd_addr_o, B_rd_data_o, B_rd_write_o
    );

    modport master (
        output A_valid_i, A_rd_addr_i, A_rd_data_i,
        output B_valid_i, B_rd_addr_i, B_rd_data_i,
        output ld_valid_i, ld_rd_addr_i, ld_data_i,
        input  ld_ready_o, ld_pending_o,
        input  A_rd_addr_o, A_rd_data_o, A_rd_write_o,
        input  B_rd_addr_o, B_rd_data_o, B_rd_write_o
    );
`endif
endinterface

// File: rtl/wb_arbiter.sv
// Writeback arbiter: lanes A/B own their write ports, buffered load returns fill idle ports.
// Optional WB_STATS_EN macro adds saturating collision and load-stall counters.
module wb_arbiter #(
    parameter int DEPTH = 4
) (
    input  logic         clock_i,
    input  logic         reset_i,
    wb_arbiter_if.slave  bus
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [4:0]    r_fifoAddr [DEPTH];
    logic [31:0]   r_fifoData [DEPTH];
    logic [AW-1:0] r_wrPtr;
    logic [AW-1:0] r_rdPtr;
    logic [PW-1:0] r_count;

    logic          r_aWrite;
    logic [4:0]    r_aAddr;
    logic [31:0]   r_aData;
    logic          r_bWrite;
    logic [4:0]    r_bAddr;
    logic [31:0]   r_bData;

    logic          w_aQual;
    logic          w_bQual;
    logic          w_collide;
    logic          w_aLaneWrite;
    logic          w_bLaneWrite;
    logic          w_ready;
    logic          w_push;
    logic          w_pop;
    logic          w_headValid;
    logic [4:0]    w_headAddr;
    logic [31:0]   w_headData;
    logic          w_headConflict;
    logic          w_aWriteNext;
    logic [4:0]    w_aAddrNext;
    logic [31:0]   w_aDataNext;
    logic          w_bWriteNext;
    logic [4:0]    w_bAddrNext;
    logic [31:0]   w_bDataNext;

    assign w_aQual      = bus.A_valid_i && (bus.A_rd_addr_i != 5'd0);
    assign w_bQual      = bus.B_valid_i && (bus.B_rd_addr_i != 5'd0);
    assign w_collide    = w_aQual && w_bQual && (bus.A_rd_addr_i == bus.B_rd_addr_i);
    assign w_aLaneWrite = w_aQual && !w_collide;
    assign w_bLaneWrite = w_bQual;

    // Ready looks only at the registered count, so a full FIFO refuses even while popping.
    assign w_ready     = (r_count != PW'(DEPTH));
    assign w_push      = bus.ld_valid_i && w_ready && (bus.ld_rd_addr_i != 5'd0);
    assign w_headValid = (r_count != '0);
    assign w_headAddr  = r_fifoAddr[r_rdPtr];
    assign w_headData  = r_fifoData[r_rdPtr];
    assign w_pop       = w_headValid && (!w_aQual || !w_bQual);

    // A lane result to the same register is younger than the queued load, so it wins.
    assign w_headConflict = (w_aLaneWrite && (w_headAddr == bus.A_rd_addr_i)) ||
                            (w_bLaneWrite && (w_headAddr == bus.B_rd_addr_i));

    always_comb begin
        w_aWriteNext = w_aLaneWrite;
        w_aAddrNext  = w_aLaneWrite ? bus.A_rd_addr_i : 5'd0;
        w_aDataNext  = w_aLaneWrite ? bus.A_rd_data_i : 32'd0;
        w_bWriteNext = w_bLaneWrite;
        w_bAddrNext  = w_bLaneWrite ? bus.B_rd_addr_i : 5'd0;
        w_bDataNext  = w_bLaneWrite ? bus.B_rd_data_i : 32'd0;
        if (w_pop && !w_headConflict) begin
            if (!w_aQual) begin
                w_aWriteNext = 1'b1;
                w_aAddrNext  = w_headAddr;
                w_aDataNext  = w_headData;
            end else begin
                w_bWriteNext = 1'b1;
                w_bAddrNext  = w_headAddr;
                w_bDataNext  = w_headData;
            end
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_aWrite <= 1'b0;
            r_aAddr  <= 5'd0;
            r_aData  <= 32'd0;
            r_bWrite <= 1'b0;
            r_bAddr  <= 5'd0;
            r_bData  <= 32'd0;
        end else begin
            r_aWrite <= w_aWriteNext;
            r_aAddr  <= w_aAddrNext;
            r_aData  <= w_aDataNext;
            r_bWrite <= w_bWriteNext;
            r_bAddr  <= w_bAddrNext;
            r_bData  <= w_bDataNext;
        end
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_wrPtr <= '0;
            r_rdPtr <= '0;
            r_count <= '0;
        end else begin
            if (w_push) begin
                r_wrPtr <= r_wrPtr + AW'(1);
            end
            if (w_pop) begin
                r_rdPtr <= r_rdPtr + AW'(1);
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + PW'(1);
            end else if (w_pop && !w_push) begin
                r_count <= r_count - PW'(1);
            end
        end
    end

    // Storage needs no reset: entries are only read once counted in.
    always_ff @(posedge clock_i) begin
        if (w_push) begin
            r_fifoAddr[r_wrPtr] <= bus.ld_rd_addr_i;
            r_fifoData[r_wrPtr] <= bus.ld_data_i;
        end
    end

    assign bus.A_rd_write_o = r_aWrite;
    assign bus.A_rd_addr_o  = r_aAddr;
    assign bus.A_rd_data_o  = r_aData;
    assign bus.B_rd_write_o = r_bWrite;
    assign bus.B_rd_addr_o  = r_bAddr;
    assign bus.B_rd_data_o  = r_bData;
    assign bus.ld_ready_o   = w_ready;
    assign bus.ld_pending_o = r_count;

`ifdef WB_STATS_EN
    logic [15:0] r_collCount;
    logic [15:0] r_stallCount;

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            r_collCount  <= 16'd0;
            r_stallCount <= 16'd0;
        end else begin
            if (w_collide && (r_collCount != 16'hFFFF)) begin
                r_collCount <= r_collCount + 16'd1;
            end
            if (bus.ld_valid_i && !w_ready && (r_stallCount != 16'hFFFF)) begin
                r_stallCount <= r_stallCount + 16'd1;
            end
        end
    end

    assign bus.collision_count_o = r_collCount;
    assign bus.ld_stall_count_o  = r_stallCount;
`endif
endmodule

// File: tb/tb_wb_arbiter.sv
// Self-checking bench for wb_arbiter: directed scenarios then random traffic against a queue model.
// Build with WB_STATS_EN defined to also check the statistics counters.
module tb_wb_arbiter;
    localparam int DEPTH = 4;

    typedef struct {
        logic [4:0]  addr;
        logic [31:0] data;
    } ldEntry_t;

    logic clock_i = 1'b0;
    logic reset_i = 1'b1;

    wb_arbiter_if #(.DEPTH(DEPTH)) bus ();

    wb_arbiter #(.DEPTH(DEPTH)) dut (
        .clock_i (clock_i),
        .reset_i (reset_i),
        .bus     (bus)
    );

    always #5 clock_i = ~clock_i;

    int checkCount = 0;
    int errorCount = 0;

    ldEntry_t    modelQ[$];
    logic        expAWrite, expBWrite, expReady;
    logic [4:0]  expAAddr, expBAddr;
    logic [31:0] expAData, expBData;
    int          expPending;
    logic [15:0] expColl, expStall;

    // All comparisons funnel through here so counts and reporting stay consistent.
    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checkCount++;
        if (actual !== expected) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic modelReset();
        modelQ.delete();
        expAWrite = 1'b0; expAAddr = 5'd0; expAData = 32'd0;
        expBWrite = 1'b0; expBAddr = 5'd0; expBData = 32'd0;
        expPending = 0;
        expReady = 1'b1;
        expColl = 16'd0;
        expStall = 16'd0;
    endtask

    // Reference behaviour for one clock edge, computed from the inputs currently applied.
    task automatic modelStep();
        logic     aQ, bQ, coll, readyNow, dropped;
        ldEntry_t head;
        aQ = bus.A_valid_i && (bus.A_rd_addr_i != 0);
        bQ = bus.B_valid_i && (bus.B_rd_addr_i != 0);
        coll = aQ && bQ && (bus.A_rd_addr_i == bus.B_rd_addr_i);
        readyNow = (modelQ.size() != DEPTH);
        expAWrite = aQ && !coll;
        expAAddr  = expAWrite ? bus.A_rd_addr_i : 5'd0;
        expAData  = expAWrite ? bus.A_rd_data_i : 32'd0;
        expBWrite = bQ;
        expBAddr  = bQ ? bus.B_rd_addr_i : 5'd0;
        expBData  = bQ ? bus.B_rd_data_i : 32'd0;
        if (modelQ.size() > 0 && (!aQ || !bQ)) begin
            head = modelQ.pop_front();
            dropped = (expAWrite && head.addr == expAAddr) || (expBWrite && head.addr == expBAddr);
            if (!dropped) begin
                if (!aQ) begin
                    expAWrite = 1'b1; expAAddr = head.addr; expAData = head.data;
                end else begin
                    expBWrite = 1'b1; expBAddr = head.addr; expBData = head.data;
                end
            end
        end
        if (bus.ld_valid_i && readyNow && bus.ld_rd_addr_i != 0) begin
            modelQ.push_back('{addr: bus.ld_rd_addr_i, data: bus.ld_data_i});
        end
        if (coll && expColl != 16'hFFFF) expColl++;
        if (bus.ld_valid_i && !readyNow && expStall != 16'hFFFF) expStall++;
        expPending = modelQ.size();
        expReady = (modelQ.size() != DEPTH);
    endtask

    task automatic compareAll(input string tag);
        checkOutput({tag, ".A_write"}, 64'(bus.A_rd_write_o), 64'(expAWrite));
        checkOutput({tag, ".A_addr"},  64'(bus.A_rd_addr_o),  64'(expAAddr));
        checkOutput({tag, ".A_data"},  64'(bus.A_rd_data_o),  64'(expAData));
        checkOutput({tag, ".B_write"}, 64'(bus.B_rd_write_o), 64'(expBWrite));
        checkOutput({tag, ".B_addr"},  64'(bus.B_rd_addr_o),  64'(expBAddr));
        checkOutput({tag, ".B_data"},  64'(bus.B_rd_data_o),  64'(expBData));
        checkOutput({tag, ".pending"}, 64'(bus.ld_pending_o), 64'(expPending));
        checkOutput({tag, ".ready"},   64'(bus.ld_ready_o),   64'(expReady));
`ifdef WB_STATS_EN
        checkOutput({tag, ".collCnt"},  64'(bus.collision_count_o), 64'(expColl));
        checkOutput({tag, ".stallCnt"}, 64'(bus.ld_stall_count_o),  64'(expStall));
`endif
    endtask

    // Called at a falling edge: apply inputs, advance the model, cross one rising edge, compare.
    task automatic applyStimulus(input string tag,
                                 input logic aV, input logic [4:0] aA, input logic [31:0] aD,
                                 input logic bV, input logic [4:0] bA, input logic [31:0] bD,
                                 input logic lV, input logic [4:0] lA, input logic [31:0] lD);
        bus.A_valid_i = aV; bus.A_rd_addr_i = aA; bus.A_rd_data_i = aD;
        bus.B_valid_i = bV; bus.B_rd_addr_i = bA; bus.B_rd_data_i = bD;
        bus.ld_valid_i = lV; bus.ld_rd_addr_i = lA; bus.ld_data_i = lD;
        modelStep();
        @(posedge clock_i);
        @(negedge clock_i);
        compareAll(tag);
    endtask

    task automatic idleCycle(input string tag);
        applyStimulus(tag, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0);
    endtask

    initial begin
        bus.A_valid_i = 1'b0; bus.A_rd_addr_i = 5'd0; bus.A_rd_data_i = 32'd0;
        bus.B_valid_i = 1'b0; bus.B_rd_addr_i = 5'd0; bus.B_rd_data_i = 32'd0;
        bus.ld_valid_i = 1'b0; bus.ld_rd_addr_i = 5'd0; bus.ld_data_i = 32'd0;
        modelReset();
        #1;
        compareAll("reset");
        @(negedge clock_i);
        @(negedge clock_i);
        reset_i = 1'b0;

        $display("[TB] collision");
        applyStimulus("coll", 1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 32'h22, 1'b0, 5'd0, 32'd0);
        checkOutput("coll.Bdata_const", 64'(bus.B_rd_data_o), 64'h22);
        checkOutput("coll.Awrite_const", 64'(bus.A_rd_write_o), 64'd0);

        $display("[TB] load drain");
        applyStimulus("drain0", 1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 32'd0, 1'b1, 5'd7, 32'hDEAD);
        applyStimulus("drain1", 1'b0, 5'd0, 32'd0, 1'b1, 5'd3, 32'h33, 1'b0, 5'd0, 32'd0);
        checkOutput("drain.Aaddr_const", 64'(bus.A_rd_addr_o), 64'd7);
        checkOutput("drain.Adata_const", 64'(bus.A_rd_data_o), 64'hDEAD);
        checkOutput("drain.Baddr_const", 64'(bus.B_rd_addr_o), 64'd3);

        $display("[TB] backpressure");
        for (int i = 0; i < 6; i++) begin
            applyStimulus("bp", 1'b1, 5'd1, 32'(i), 1'b1, 5'd2, 32'(i + 100),
                          (i < 5), 5'(10 + i), 32'(16'hA000 + i));
            if (i == 3) begin
                checkOutput("bp.ready_full", 64'(bus.ld_ready_o), 64'd0);
            end
        end
        checkOutput("bp.pending_const", 64'(bus.ld_pending_o), 64'd4);
        for (int i = 0; i < 4; i++) begin
            idleCycle("bpDrain");
            checkOutput("bp.order", 64'(bus.A_rd_addr_o), 64'(10 + i));
        end

        $display("[TB] rd zero");
        applyStimulus("rd0", 1'b1, 5'd0, 32'h55, 1'b0, 5'd0, 32'd0, 1'b1, 5'd0, 32'h66);
        idleCycle("rd0b");
        checkOutput("rd0.pending_const", 64'(bus.ld_pending_o), 64'd0);

        $display("[TB] reset mid-stream");
        for (int i = 0; i < 3; i++) begin
            applyStimulus("rstFill", 1'b1, 5'd8, 32'd1, 1'b1, 5'd9, 32'd2,
                          1'b1, 5'(20 + i), 32'(i));
        end
        reset_i = 1'b1;
        modelReset();
        #1;
        compareAll("rstAsync");
        @(negedge clock_i);
        reset_i = 1'b0;
        idleCycle("rstAfter");

        $display("[TB] random traffic");
        for (int i = 0; i < 400; i++) begin
            applyStimulus("rand",
                          ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                          ($urandom_range(0, 9) < 6), 5'($urandom_range(0, 7)), $urandom,
                          ($urandom_range(0, 9) < 5), 5'($urandom_range(0, 7)), $urandom);
        end
        for (int i = 0; i < DEPTH + 1; i++) begin
            idleCycle("flush");
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end
endmodule
